hbm_fixed_latency_endpoint: RTL and testbench

//  Cycle-accurate HBM endpoint for the compute tile array: sits downstream of the tile DMA/NoC

---
 rtl/hbm_fixed_latency_endpoint.sv | 193 +++++++++++++++++++
 tb/tb_hbm_fixed_latency_endpoint.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_fixed_latency_endpoint.sv
// hbm_fixed_latency_endpoint
// Fixed-latency HBM endpoint model for the compute tile array. Requests are
// accepted into a circular FIFO and each one is answered, in acceptance order,
// exactly Latency cycles after its handshake. A response can be later than that
// only when the response channel applies backpressure.
//
// Optional feature: define HBM_LAT_EP_STATS_EN to add the stat_txn_cnt_o and
// stat_stall_cnt_o counter outputs. Without the macro those ports and counters
// do not exist and the core behaviour is unchanged.

module hbm_fixed_latency_endpoint #(
    parameter int Latency   = 100,
    parameter int MaxTxns   = 32,
    parameter int IdWidth   = 4,
    parameter int AddrWidth = 48
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IdWidth-1:0]   req_id_i,
    input  logic [AddrWidth-1:0] req_addr_i,
    input  logic                 req_write_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [IdWidth-1:0]   rsp_id_o,
    output logic [AddrWidth-1:0] rsp_addr_o,
    output logic                 rsp_write_o,
    output logic                 busy_o
`ifdef HBM_LAT_EP_STATS_EN
    ,
    output logic [31:0]          stat_txn_cnt_o,
    output logic [31:0]          stat_stall_cnt_o
`endif
);

    // Counter, pointer and occupancy widths. A single-entry FIFO still needs a
    // one-bit pointer so that the arrays stay addressable.
    localparam int CntW = $clog2(Latency + 1);
    localparam int PtrW = (MaxTxns > 1) ? $clog2(MaxTxns) : 1;
    localparam int OccW = $clog2(MaxTxns + 1);

    localparam logic [CntW-1:0] InitCnt = CntW'(Latency - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxTxns - 1);
    localparam logic [OccW-1:0] FullOcc = OccW'(MaxTxns);

    // Elaboration-time parameter sanity checks.
    if (Latency < 1) begin : gLatencyCheck
        $error("hbm_fixed_latency_endpoint: Latency must be >= 1");
    end
    if (MaxTxns < 1) begin : gMaxTxnsCheck
        $error("hbm_fixed_latency_endpoint: MaxTxns must be >= 1");
    end

    // Entry payload storage; it is never reset because the outputs are masked
    // whenever the FIFO is empty.
    logic [IdWidth-1:0]   idMem_q    [MaxTxns];
    logic [AddrWidth-1:0] addrMem_q  [MaxTxns];
    logic [MaxTxns-1:0]   writeMem_q;

    // Per-entry countdown to the cycle the entry may be presented.
    logic [CntW-1:0] waitCnt_q [MaxTxns];
    logic [CntW-1:0] waitCnt_d [MaxTxns];

    logic [PtrW-1:0] wrPtr_q, wrPtr_d;
    logic [PtrW-1:0] rdPtr_q, rdPtr_d;
    logic [OccW-1:0] occ_q, occ_d;

    logic [MaxTxns-1:0] occupied;
    logic               headReady;
    logic               push;
    logic               pop;

    assign req_ready_o = (occ_q < FullOcc);
    assign busy_o      = (occ_q != '0);
    assign headReady   = busy_o && (waitCnt_q[rdPtr_q] == '0);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = headReady && rsp_ready_i;

    assign rsp_valid_o = headReady;
    assign rsp_id_o    = busy_o ? idMem_q[rdPtr_q]    : '0;
    assign rsp_addr_o  = busy_o ? addrMem_q[rdPtr_q]  : '0;
    assign rsp_write_o = busy_o ? writeMem_q[rdPtr_q] : 1'b0;

    // Mark which slots hold live entries: slot i is live when its distance
    // from the read pointer (modulo the depth) is below the occupancy.
    always_comb begin
        int offset;
        offset   = 0;
        occupied = '0;
        for (int i = 0; i < MaxTxns; i++) begin
            offset = i - int'(rdPtr_q);
            if (offset < 0) begin
                offset = offset + MaxTxns;
            end
            occupied[i] = (offset < int'(occ_q));
        end
    end

    // Pointer and occupancy next state; a simultaneous push and pop moves both
    // pointers and leaves the occupancy unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        occ_d   = occ_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == LastPtr) ? '0 : wrPtr_q + PtrW'(1);
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == LastPtr) ? '0 : rdPtr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Countdown next state: every live entry keeps counting toward zero even
    // while the head is stalled, so queued responses follow without bubbles.
    // The slot written this cycle starts at Latency-1 and is not decremented.
    always_comb begin
        for (int i = 0; i < MaxTxns; i++) begin
            waitCnt_d[i] = waitCnt_q[i];
            if (occupied[i] && (waitCnt_q[i] != '0)) begin
                waitCnt_d[i] = waitCnt_q[i] - CntW'(1);
            end
            if (push && (wrPtr_q == PtrW'(i))) begin
                waitCnt_d[i] = InitCnt;
            end
        end
    end

    // Control state registers; reset drops every outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < MaxTxns; i++) begin
                waitCnt_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            occ_q   <= occ_d;
            for (int i = 0; i < MaxTxns; i++) begin
                waitCnt_q[i] <= waitCnt_d[i];
            end
        end
    end

    // Capture the request payload into the slot at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idMem_q[wrPtr_q]    <= req_id_i;
            addrMem_q[wrPtr_q]  <= req_addr_i;
            writeMem_q[wrPtr_q] <= req_write_i;
        end
    end

`ifdef HBM_LAT_EP_STATS_EN
    logic [31:0] statTxn_q;
    logic [31:0] statStall_q;

    // Count completed responses and cycles where a response waits on the sink.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            statTxn_q   <= '0;
            statStall_q <= '0;
        end else begin
            if (pop) begin
                statTxn_q <= statTxn_q + 32'd1;
            end
            if (rsp_valid_o && !rsp_ready_i) begin
                statStall_q <= statStall_q + 32'd1;
            end
        end
    end

    assign stat_txn_cnt_o   = statTxn_q;
    assign stat_stall_cnt_o = statStall_q;
`endif

    // A presented response must hold steady until the sink takes it.
    property pRspStable;
        @(posedge clk_i) disable iff (rst_i)
            (rsp_valid_o && !rsp_ready_i) |=>
                (rsp_valid_o && $stable(rsp_id_o) && $stable(rsp_addr_o) && $stable(rsp_write_o));
    endproperty
    aRspStable: assert property (pRspStable);

endmodule

// File: tb/tb_hbm_fixed_latency_endpoint.sv
// tb_hbm_fixed_latency_endpoint
// Scoreboard bench for hbm_fixed_latency_endpoint. Two instances are driven:
// instance 0 with Latency=100 / MaxTxns=32 and instance 1 with Latency=1 /
// MaxTxns=4. Accepted requests are pushed into an expected queue tagged with
// the cycle they become due; a negedge monitor checks every output each cycle
// and pops the queue on each response handshake. With HBM_LAT_EP_STATS_EN the
// statistics counters are checked too.

module tb_hbm_fixed_latency_endpoint;

   typedef struct {
      int          inst;
      logic [3:0]  id;
      logic [47:0] addr;
      logic        wr;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        reqValid  [2];
   logic        reqReady  [2];
   logic [3:0]  reqId     [2];
   logic [47:0] reqAddr   [2];
   logic        reqWrite  [2];
   logic        rspValid  [2];
   logic        rspReady  [2];
   logic [3:0]  rspId     [2];
   logic [47:0] rspAddr   [2];
   logic        rspWrite  [2];
   logic        busy      [2];
`ifdef HBM_LAT_EP_STATS_EN
   logic [31:0] statTxn   [2];
   logic [31:0] statStall [2];
`endif

   exp_t expQ[$];
   int   lastPop [2];
   int   cyc       = 0;
   int   total     = 0;
   int   passed    = 0;
   bit   monitorOn = 1'b0;

   hbm_fixed_latency_endpoint #(
      .Latency(100), .MaxTxns(32), .IdWidth(4), .AddrWidth(48)
   ) dut0 (
      .clk_i(clk), .rst_i(rst[0]),
      .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]),
      .req_id_i(reqId[0]), .req_addr_i(reqAddr[0]), .req_write_i(reqWrite[0]),
      .rsp_valid_o(rspValid[0]), .rsp_ready_i(rspReady[0]),
      .rsp_id_o(rspId[0]), .rsp_addr_o(rspAddr[0]), .rsp_write_o(rspWrite[0]),
      .busy_o(busy[0])
`ifdef HBM_LAT_EP_STATS_EN
      , .stat_txn_cnt_o(statTxn[0]), .stat_stall_cnt_o(statStall[0])
`endif
   );

   hbm_fixed_latency_endpoint #(
      .Latency(1), .MaxTxns(4), .IdWidth(4), .AddrWidth(48)
   ) dut1 (
      .clk_i(clk), .rst_i(rst[1]),
      .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]),
      .req_id_i(reqId[1]), .req_addr_i(reqAddr[1]), .req_write_i(reqWrite[1]),
      .rsp_valid_o(rspValid[1]), .rsp_ready_i(rspReady[1]),
      .rsp_id_o(rspId[1]), .rsp_addr_o(rspAddr[1]), .rsp_write_o(rspWrite[1]),
      .busy_o(busy[1])
`ifdef HBM_LAT_EP_STATS_EN
      , .stat_txn_cnt_o(statTxn[1]), .stat_stall_cnt_o(statStall[1])
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Cycle index; read at the negedge it names the current cycle.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int latOf(input int k);
      return (k == 0) ? 100 : 1;
   endfunction

   function automatic int depthOf(input int k);
      return (k == 0) ? 32 : 4;
   endfunction

   function automatic int headIdx(input int k);
      for (int i = 0; i < expQ.size(); i++) begin
         if (expQ[i].inst == k) return i;
      end
      return -1;
   endfunction

   function automatic int occOf(input int k);
      int n = 0;
      for (int i = 0; i < expQ.size(); i++) begin
         if (expQ[i].inst == k) n++;
      end
      return n;
   endfunction

   // One scored comparison.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
      end else begin
         passed++;
      end
   endtask

   // Drive one request and hold it until accepted; record the expected response.
   task automatic applyStimulus(input int k, input logic [3:0] id, input logic [47:0] addr,
                                input logic wr, output int accCyc);
      bit got = 1'b0;
      accCyc      = -1;
      reqValid[k] = 1'b1;
      reqId[k]    = id;
      reqAddr[k]  = addr;
      reqWrite[k] = wr;
      for (int n = 0; n < 3000 && !got; n++) begin
         @(negedge clk);
         #1;
         if (reqReady[k] === 1'b1) begin
            got    = 1'b1;
            accCyc = cyc;
            expQ.push_back('{inst: k, id: id, addr: addr, wr: wr, due: cyc + latOf(k)});
         end
      end
      if (!got) begin
         total++;
         $display("[TB] FAIL req_accept_timeout inst %0d: actual=not accepted required=accepted", k);
      end
      @(posedge clk);
      #1;
      reqValid[k] = 1'b0;
   endtask

   task automatic idle(input int k, input int n);
      reqValid[k] = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One-cycle synchronous reset; the model drops everything outstanding.
   task automatic resetDut(input int k);
      @(posedge clk);
      #1;
      rst[k]      = 1'b1;
      reqValid[k] = 1'b0;
      @(negedge clk);
      #1;
      for (int i = expQ.size() - 1; i >= 0; i--) begin
         if (expQ[i].inst == k) expQ.delete(i);
      end
      lastPop[k] = -1;
      @(posedge clk);
      #1;
      rst[k] = 1'b0;
   endtask

   task automatic waitDrain(input int k, input int budget);
      int n = 0;
      while (occOf(k) != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (occOf(k) != 0) begin
         total++;
         $display("[TB] FAIL drain_timeout inst %0d: actual=%0d outstanding required=0", k, occOf(k));
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every output against the model, then retire handshakes.
   always @(negedge clk) begin : monitor
      int   h;
      int   occ;
      int   earliest;
      logic expValid;
      if (monitorOn) begin
         for (int k = 0; k < 2; k++) begin
            h        = headIdx(k);
            occ      = occOf(k);
            expValid = 1'b0;
            if (h >= 0) begin
               earliest = (expQ[h].due > lastPop[k] + 1) ? expQ[h].due : lastPop[k] + 1;
               expValid = (cyc >= earliest);
            end
            checkOutput($sformatf("rsp_valid[%0d]", k), 64'(rspValid[k]), 64'(expValid));
            checkOutput($sformatf("req_ready[%0d]", k), 64'(reqReady[k]), 64'(occ < depthOf(k)));
            checkOutput($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(occ != 0));
            if (occ == 0) begin
               checkOutput($sformatf("rsp_idle_fields[%0d]", k),
                           64'({rspWrite[k], rspId[k], rspAddr[k]}), 64'd0);
            end
            if (h >= 0 && rspValid[k] === 1'b1) begin
               checkOutput($sformatf("rsp_id[%0d]", k), 64'(rspId[k]), 64'(expQ[h].id));
               checkOutput($sformatf("rsp_addr[%0d]", k), 64'(rspAddr[k]), 64'(expQ[h].addr));
               checkOutput($sformatf("rsp_write[%0d]", k), 64'(rspWrite[k]), 64'(expQ[h].wr));
               if (rspReady[k] === 1'b1) begin
                  expQ.delete(h);
                  lastPop[k] = cyc;
               end
            end
         end
      end
   end

   // Directed scenarios followed by randomized traffic on both instances.
   initial begin
      int  acc;
      int  accFirst;
      int  acc33;
      int  t0;
      bit  done;
      for (int k = 0; k < 2; k++) begin
         rst[k]      = 1'b1;
         reqValid[k] = 1'b0;
         reqId[k]    = '0;
         reqAddr[k]  = '0;
         reqWrite[k] = 1'b0;
         rspReady[k] = 1'b1;
         lastPop[k]  = -1;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0]    = 1'b0;
      rst[1]    = 1'b0;
      monitorOn = 1'b1;

      // Single read, Latency 100.
      $display("[TB] single read");
      idle(0, 10);
      applyStimulus(0, 4'd3, 48'h1000, 1'b0, acc);
      waitDrain(0, 300);
      checkOutput("t1_rsp_cycle", 64'(lastPop[0]), 64'(acc + 100));

      // 32 back-to-back requests, sink always ready.
      $display("[TB] 32 back-to-back");
      accFirst = -1;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 4'(i), 48'($urandom) << 8, 1'($urandom), acc);
         if (i == 0) accFirst = acc;
      end
      checkOutput("t2_accept_span", 64'(acc - accFirst), 64'd31);
      waitDrain(0, 300);
      checkOutput("t2_last_rsp", 64'(lastPop[0]), 64'(accFirst + 131));

      // 33 requests against a stalled sink, released at t0+200.
      $display("[TB] full FIFO with backpressure");
      resetDut(0);
      rspReady[0] = 1'b0;
      t0          = cyc;
      accFirst    = -1;
      acc33       = -1;
      fork
         begin
            for (int i = 0; i < 33; i++) begin
               applyStimulus(0, 4'(i), 48'h4000 + 48'(i), 1'(i), acc);
               if (i == 0)  accFirst = acc;
               if (i == 32) acc33 = acc;
            end
         end
         begin
            while (cyc != t0 + 200) begin
               @(posedge clk);
               #1;
            end
            rspReady[0] = 1'b1;
         end
      join
      checkOutput("t3_first_accept", 64'(accFirst), 64'(t0));
      checkOutput("t3_33rd_accept", 64'(acc33), 64'(t0 + 201));
      waitDrain(0, 400);
      checkOutput("t3_33rd_rsp", 64'(lastPop[0]), 64'(t0 + 301));
`ifdef HBM_LAT_EP_STATS_EN
      checkOutput("stat_txn_cnt", 64'(statTxn[0]), 64'd33);
      checkOutput("stat_stall_cnt", 64'(statStall[0]), 64'd100);
`endif

      // Reset with five requests in flight; none may ever respond.
      $display("[TB] reset mid-operation");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 4'(i + 8), 48'h9000 + 48'(i), 1'b1, acc);
      end
      idle(0, 20);
      resetDut(0);
`ifdef HBM_LAT_EP_STATS_EN
      checkOutput("stat_txn_after_reset", 64'(statTxn[0]), 64'd0);
`endif
      idle(0, 150);

      // Randomized traffic with bursty backpressure, Latency 100.
      $display("[TB] random traffic, Latency 100");
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 60; n++) begin
               applyStimulus(0, 4'($urandom), 48'({$urandom, $urandom}), 1'($urandom), acc);
               idle(0, $urandom_range(0, 3));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               rspReady[0] = ($urandom_range(0, 2) != 0);
               repeat ($urandom_range(1, 20)) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
      join
      rspReady[0] = 1'b1;
      waitDrain(0, 500);

      // Latency 1: one request per cycle, responses one cycle later, no gaps.
      $display("[TB] Latency 1 streaming");
      accFirst = -1;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 4'(i), 48'h77_0000 + 48'(i), 1'(i >> 1), acc);
         if (i == 0) accFirst = acc;
      end
      checkOutput("t4_accept_span", 64'(acc - accFirst), 64'd19);
      waitDrain(1, 20);
      checkOutput("t4_last_rsp", 64'(lastPop[1]), 64'(acc + 1));

      // Randomized traffic on the shallow, Latency 1 instance.
      $display("[TB] random traffic, Latency 1");
      done = 1'b0;
      fork
         begin
            for (int n = 0; n < 120; n++) begin
               applyStimulus(1, 4'($urandom), 48'({$urandom, $urandom}), 1'($urandom), acc);
               idle(1, $urandom_range(0, 1));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               rspReady[1] = 1'($urandom);
               @(posedge clk);
               #1;
            end
         end
      join
      rspReady[1] = 1'b1;
      waitDrain(1, 100);

      idle(0, 5);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
